branch_target_aligner: RTL and testbench



---
 rtl/branch_target_aligner.sv | 129 ++++++++++++
 tb/tb_branch_target_aligner.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_aligner.sv
// Two-stage branch-target generator: sign-extend and align the offset, then add to the prefetch-adjusted PC.
// Valid/ready on both sides; flush kills both stages, reset clears valids and result data.
module branch_target_aligner #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OFF_W     = 24,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OFF_W-1:0] offset,
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] aligned_off,
    output logic             align_err
);

    localparam int unsigned SHW   = 2;
    localparam int unsigned EXT_W = WIDTH - OFF_W;
    localparam logic [1:0]  MODE_WORD = 2'b00;
    localparam logic [1:0]  MODE_HALF = 2'b01;
    localparam logic [1:0]  MODE_BYTE = 2'b10;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_aligned;
    logic [SHW-1:0]   w_shift;
    logic             w_err;
    logic [WIDTH-1:0] w_target;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_pc;
    logic [WIDTH-1:0] r_s1_aligned;
    logic             r_s1_err;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_target;
    logic [WIDTH-1:0] r_s2_aligned;
    logic             r_s2_err;

    // Pipeline advance conditions; in_ready never looks at in_valid.
    always_comb begin
        w_s2_adv = !r_s2_valid || out_ready;
        w_s1_adv = r_s1_valid && w_s2_adv;
        in_ready = !r_s1_valid || w_s1_adv;
        w_accept = in_valid && in_ready && !flush;
    end

    // Reserved mode aligns like word mode but always flags an error.
    always_comb begin
        w_ext   = {{EXT_W{offset[OFF_W-1]}}, offset};
        w_shift = SHW'(2);
        w_err   = 1'b1;
        case (mode)
            MODE_WORD: begin
                w_shift = SHW'(2);
                w_err   = |pc[1:0];
            end
            MODE_HALF: begin
                w_shift = SHW'(1);
                w_err   = pc[0];
            end
            MODE_BYTE: begin
                w_shift = SHW'(0);
                w_err   = 1'b0;
            end
            default: ;
        endcase
        w_aligned = w_ext << w_shift;
        w_target  = r_s1_pc + WIDTH'(PC_OFFSET) + r_s1_aligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage payloads only load on a transfer, so a stalled result holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_pc      <= '0;
            r_s1_aligned <= '0;
            r_s1_err     <= 1'b0;
            r_s2_target  <= '0;
            r_s2_aligned <= '0;
            r_s2_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_pc      <= pc;
                r_s1_aligned <= w_aligned;
                r_s1_err     <= w_err;
            end
            if (w_s1_adv && !flush) begin
                r_s2_target  <= w_target;
                r_s2_aligned <= r_s1_aligned;
                r_s2_err     <= r_s1_err;
            end
        end
    end

    always_comb begin
        out_valid   = r_s2_valid;
        target      = r_s2_target;
        aligned_off = r_s2_aligned;
        align_err   = r_s2_err;
    end

endmodule

// File: tb/tb_branch_target_aligner.sv
// Self-checking bench for branch_target_aligner: directed vectors plus a queue-based
// reference model compared against the DUT on every cycle.
module tb_branch_target_aligner;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] offset;
    logic [31:0] pc;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] target;
    logic [31:0] aligned_off;
    logic        align_err;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_out    = 0;

    bit          drv_lit;
    logic [31:0] drv_lt;
    logic [31:0] drv_la;
    logic        drv_le;

    typedef struct {
        logic [31:0] target;
        logic [31:0] aligned;
        logic        err;
        int          age;
        bit          lit;
        logic [31:0] lt;
        logic [31:0] la;
        logic        le;
    } exp_t;

    exp_t q[$];

    branch_target_aligner #(.WIDTH(32), .OFF_W(24), .PC_OFFSET(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .offset(offset), .pc(pc), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .target(target), .aligned_off(aligned_off), .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed offset times the unit size, plus pc + 8, all modulo 2^32.
    function automatic exp_t model(input logic [31:0] p, input logic [23:0] o, input logic [1:0] m);
        exp_t   e;
        longint s;
        longint mul;
        longint a;
        longint t;
        s = longint'(o);
        if (o[23]) s = s - 64'sd16777216;
        mul = (m == 2'b01) ? 2 : (m == 2'b10) ? 1 : 4;
        a = s * mul;
        t = longint'(p) + 64'sd8 + a;
        e.aligned = a[31:0];
        e.target  = t[31:0];
        case (m)
            2'b00:   e.err = (p % 4) != 0;
            2'b01:   e.err = (p % 2) != 0;
            2'b10:   e.err = 1'b0;
            default: e.err = 1'b1;
        endcase
        e.age = 0;
        e.lit = 1'b0;
        e.lt  = '0;
        e.la  = '0;
        e.le  = 1'b0;
        return e;
    endfunction

    // Compare process: sample at negedge, advance the model at the following posedge.
    initial begin : monitor
        bit          ev, take, acc, stall_prev, stall_next;
        logic [31:0] stall_t;
        exp_t        e;
        stall_prev = 1'b0;
        stall_t    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                stall_prev = 1'b0;
                continue;
            end
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            ev = (q.size() > 0) && (q[0].age >= 1);
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev && out_valid) begin
                chk("target", target, q[0].target);
                chk("aligned_off", aligned_off, q[0].aligned);
                chk("align_err", 32'(align_err), 32'(q[0].err));
                if (q[0].lit) begin
                    chk("target_literal", target, q[0].lt);
                    chk("aligned_literal", aligned_off, q[0].la);
                    chk("err_literal", 32'(align_err), 32'(q[0].le));
                end
            end
            if (stall_prev) chk("stall_stable", target, stall_t);
            take = ev && out_ready && !flush;
            acc  = in_valid && ((q.size() < 2) || out_ready) && !flush;
            if (acc) begin
                e     = model(pc, offset, mode);
                e.lit = drv_lit;
                e.lt  = drv_lt;
                e.la  = drv_la;
                e.le  = drv_le;
            end
            stall_next = ev && !out_ready && !flush;
            stall_t    = target;
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                stall_prev = 1'b0;
                continue;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (take) begin
                    void'(q.pop_front());
                    n_out++;
                end
                foreach (q[i]) q[i].age++;
                if (acc) begin
                    q.push_back(e);
                    n_acc++;
                end
            end
            stall_prev = stall_next;
        end
    end

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] p, input logic [23:0] o, input logic [1:0] m,
                        input bit lit, input logic [31:0] lt, input logic [31:0] la, input logic le);
        bit got;
        int budget;
        in_valid = 1'b1;
        pc       = p;
        offset   = o;
        mode     = m;
        drv_lit  = lit;
        drv_lt   = lt;
        drv_la   = la;
        drv_le   = le;
        budget   = 0;
        got      = 1'b0;
        while (!got && budget < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            budget++;
        end
        if (!got) begin
            n_err++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", budget);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        drv_lit  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] p;
        logic [23:0] o;
        logic [1:0]  m;
        logic [31:0] t;
        logic [31:0] a;
        logic        e;
    } vec_t;

    vec_t vecs[10];
    int   pat[14];

    initial begin
        vecs[0] = '{32'h0000_1000, 24'h000010, 2'b00, 32'h0000_1048, 32'h0000_0040, 1'b0};
        vecs[1] = '{32'h0000_1000, 24'hFFFFFE, 2'b00, 32'h0000_1000, 32'hFFFF_FFF8, 1'b0};
        vecs[2] = '{32'h0000_1000, 24'hFFFFFE, 2'b01, 32'h0000_1004, 32'hFFFF_FFFC, 1'b0};
        vecs[3] = '{32'h0000_1000, 24'hFFFFFE, 2'b10, 32'h0000_1006, 32'hFFFF_FFFE, 1'b0};
        vecs[4] = '{32'hFFFF_FFF8, 24'h000001, 2'b00, 32'h0000_0004, 32'h0000_0004, 1'b0};
        vecs[5] = '{32'h0000_1002, 24'h000010, 2'b00, 32'h0000_104A, 32'h0000_0040, 1'b1};
        vecs[6] = '{32'h0000_1000, 24'h000010, 2'b11, 32'h0000_1048, 32'h0000_0040, 1'b1};
        vecs[7] = '{32'h0000_1001, 24'h000000, 2'b01, 32'h0000_1009, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'h0000_1003, 24'h7FFFFF, 2'b10, 32'h0080_100A, 32'h007F_FFFF, 1'b0};
        vecs[9] = '{32'h0000_1000, 24'h800000, 2'b00, 32'hFE00_1008, 32'hFE00_0000, 1'b0};
        pat = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        offset    = '0;
        pc        = '0;
        mode      = '0;
        out_ready = 1'b1;
        drv_lit   = 1'b0;
        drv_lt    = '0;
        drv_la    = '0;
        drv_le    = 1'b0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_aligned", aligned_off, 32'd0);
        chk("rst_err", 32'(align_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors back-to-back at full throughput.
        foreach (vecs[i]) send(vecs[i].p, vecs[i].o, vecs[i].m, 1'b1, vecs[i].t, vecs[i].a, vecs[i].e);
        idle(5);

        // Backpressure: six requests while out_ready follows a fixed pattern.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h0000_0100 * (i + 1), 24'(i + 1), 2'(i % 3), 1'b0, '0, '0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    out_ready = pat[k][0];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(6);

        // Flush with both stages full and a same-cycle request.
        out_ready = 1'b0;
        send(32'h0000_2000, 24'h000001, 2'b00, 1'b0, '0, '0, 1'b0);
        send(32'h0000_3000, 24'h000002, 2'b00, 1'b0, '0, '0, 1'b0);
        pc       = 32'h0000_4000;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);

        // Asynchronous reset between edges with both stages full.
        out_ready = 1'b0;
        send(32'h0000_6000, 24'h000003, 2'b00, 1'b0, '0, '0, 1'b0);
        send(32'h0000_7000, 24'h000004, 2'b01, 1'b0, '0, '0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_target", target, 32'd0);
        chk("arst_aligned", aligned_off, 32'd0);
        chk("arst_err", 32'(align_err), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(3);
        send(32'h0000_5000, 24'h000004, 2'b00, 1'b1, 32'h0000_5018, 32'h0000_0010, 1'b0);
        idle(5);

        chk("model_drained", 32'(q.size()), 32'd0);
        chk("delivered_count", 32'(n_out), 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
